// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the data-memory path: funct3 width/sign codes,
// controller state encoding and byte-enable width.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_ACCESS,
    MEM_RESP
  } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised single-port data RAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset.
module data_mem_array
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BE_W-1:0]       be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: valid/ready request, programmable wait states,
// byte/half/word access with load extension and a one-cycle response pulse.
module data_mem_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        mem_clk,
  input  logic        mem_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic        ready_q, ready_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                  is_byte, is_half, is_word;
  logic                  f3_illegal, misaligned, out_of_range, acc_err;
  logic [BE_W-1:0]       lane_be, ram_be;
  logic [31:0]           ram_wdata, ram_rdata, lane, load_data;
  logic [DEPTH_LOG2-1:0] ram_addr;

  // In IDLE the RAM is pointed at the incoming address so a zero-wait load
  // has its word ready in ACCESS; afterwards it tracks the latched address.
  assign ram_addr = (state_q == MEM_IDLE) ? req_addr[DEPTH_LOG2+1:2] : addr_q[DEPTH_LOG2+1:2];

  data_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (mem_clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    is_byte      = (f3_q == F3_B) || (f3_q == F3_BU);
    is_half      = (f3_q == F3_H) || (f3_q == F3_HU);
    is_word      = (f3_q == F3_W);
    f3_illegal   = !(is_byte || is_half || is_word) ||
                   (we_q && ((f3_q == F3_BU) || (f3_q == F3_HU)));
    misaligned   = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
    out_of_range = (addr_q >> (DEPTH_LOG2 + 2)) != 32'd0;
    acc_err      = f3_illegal || misaligned || out_of_range;

    if (is_word) begin
      lane_be   = 4'b1111;
      ram_wdata = wdata_q;
    end else if (is_half) begin
      lane_be   = 4'b0011 << addr_q[1:0];
      ram_wdata = {2{wdata_q[15:0]}};
    end else begin
      lane_be   = 4'b0001 << addr_q[1:0];
      ram_wdata = {4{wdata_q[7:0]}};
    end
    ram_be = (state_q == MEM_ACCESS && we_q && !acc_err) ? lane_be : '0;

    lane = ram_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      MEM_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          if (WAIT_CYCLES == 0) begin
            state_d = MEM_ACCESS;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_ACCESS: begin
        state_d = MEM_RESP;
        err_d   = acc_err;
        rdata_d = (acc_err || we_q) ? 32'd0 : load_data;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase

    ready_d = (state_d == MEM_IDLE);
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q <= MEM_IDLE;
      ready_q <= 1'b0;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == MEM_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, zero-wait streaming,
// mid-transaction reset and randomized traffic against a byte-level model.
module tb_data_mem_ctrl;
  import rv32i_pkg::*;

  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;

  logic        z_rst_n, z_valid, z_ready, z_we, z_rsp_valid, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [2:0]  z_f3;

  data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(W2)) dut (
    .mem_clk(clk), .mem_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .mem_clk(clk), .mem_rst_n(z_rst_n), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata), .req_funct3(z_f3),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] mb [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] rd, input logic er);
    vec_t v;
    v.name = nm; v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3; v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endtask

  // Reference: size/sign from funct3, byte-addressed memory, plain arithmetic.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int sz;
    bit sgn, ill;
    longint unsigned v;
    sz = 1; sgn = 0; ill = 0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: ill = 1;
    endcase
    if (we && f3 > 3'd2) ill = 1;
    er = ill || ((a % sz) != 0) || (a >= 32'h1000);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < sz; k++) mb[int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++) v = v | (longint'(mb[int'(a) + k]) << (8*k));
        if (sgn && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        rd = v[31:0];
      end
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; starts and ends on a negedge.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int n;
    bit ok;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    n = 0; ok = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (req_ready !== 1'b0) ok = 0;
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b0) ok = 0;
    chk("rsp_latency", n, W2 + 1);
    chk("ready_low_busy", {31'd0, ok}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    chk("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
    chk("ready_returns", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, exp_er, we;
    logic [2:0]  f3;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = F3_W;
    z_rst_n = 1'b0; z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'hCAFEF00D; z_f3 = F3_W;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_z_ready", {31'd0, z_ready}, 32'd0);
    rst_n = 1'b1; z_rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Zero wait states with valid held high: accept, ACCESS, RESP, repeat.
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("z_ready_k%0d", k), {31'd0, z_ready}, {31'd0, (k % 3) == 0});
      chk($sformatf("z_rsp_valid_k%0d", k), {31'd0, z_rsp_valid}, {31'd0, (k % 3) == 2});
      if (k % 3 == 2) begin
        chk($sformatf("z_rdata_k%0d", k), z_rdata, (k > 9) ? 32'hCAFEF00D : 32'd0);
        chk($sformatf("z_err_k%0d", k), {31'd0, z_err}, 32'd0);
      end
      if (k == 8) begin
        z_we = 1'b0; z_wdata = 32'h0;
      end
      @(negedge clk);
    end
    z_valid = 1'b0;

    add("sw_deadbeef", 1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0);
    add("lw_deadbeef", 0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 0);
    add("sw_clear",    1, 32'h10, 32'h0, F3_W, 32'h0, 0);
    add("sb_80",       1, 32'h13, 32'h00000080, F3_B, 32'h0, 0);
    add("lb_13",       0, 32'h13, 32'h0, F3_B, 32'hFFFFFF80, 0);
    add("lbu_13",      0, 32'h13, 32'h0, F3_BU, 32'h00000080, 0);
    add("lw_10",       0, 32'h10, 32'h0, F3_W, 32'h80000000, 0);
    add("lh_12",       0, 32'h12, 32'h0, F3_H, 32'hFFFF8000, 0);
    add("lhu_12",      0, 32'h12, 32'h0, F3_HU, 32'h00008000, 0);
    add("sw_20",       1, 32'h20, 32'hA5A5A5A5, F3_W, 32'h0, 0);
    add("lh_mis_21",   0, 32'h21, 32'h0, F3_H, 32'h0, 1);
    add("sw_mis_22",   1, 32'h22, 32'h11111111, F3_W, 32'h0, 1);
    add("lw_20",       0, 32'h20, 32'h0, F3_W, 32'hA5A5A5A5, 0);
    add("sw_0",        1, 32'h0, 32'h0BADF00D, F3_W, 32'h0, 0);
    add("lw_oor",      0, 32'h1000, 32'h0, F3_W, 32'h0, 1);
    add("sw_oor",      1, 32'h1000, 32'hFFFFFFFF, F3_W, 32'h0, 1);
    add("lw_0_kept",   0, 32'h0, 32'h0, F3_W, 32'h0BADF00D, 0);
    add("ld_f3_011",   0, 32'h0, 32'h0, 3'b011, 32'h0, 1);
    add("st_f3_100",   1, 32'h0, 32'h12345678, F3_BU, 32'h0, 1);
    add("sh_2",        1, 32'h2, 32'h1234ABCD, F3_H, 32'h0, 0);
    add("lw_0_sh",     0, 32'h0, 32'h0, F3_W, 32'hABCDF00D, 0);

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Reset during WAIT of a store: no response, no write.
    xact(1, 32'h40, 32'h55AA55AA, F3_W, rd, er);
    chk("pre_abort_err", {31'd0, er}, 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_funct3 = F3_W;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ready_now", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd0);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", {31'd0, req_ready}, 32'd1);
    xact(0, 32'h40, 32'h0, F3_W, rd, er);
    chk("abort_lw_rdata", rd, 32'h55AA55AA);
    chk("abort_lw_err", {31'd0, er}, 32'd0);

    // Randomized traffic over the first 64 bytes plus out-of-range hits.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1, 32'(w * 4), wd, F3_W, exp_rd, exp_er);
      xact(1, 32'(w * 4), wd, F3_W, rd, er);
      chk("prefill_err", {31'd0, er}, {31'd0, exp_er});
    end
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, 63));
      model(we, a, wd, f3, exp_rd, exp_er);
      xact(we, a, wd, f3, rd, er);
      chk($sformatf("rnd%0d_rdata we=%0d a=%08h f3=%0d", i, we, a, f3), rd, exp_rd);
      chk($sformatf("rnd%0d_err we=%0d a=%08h f3=%0d", i, we, a, f3), {31'd0, er}, {31'd0, exp_er});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
